// File: rtl/fe_tx_framer.sv
// Response-frame transmitter: sends cmd byte, 16-bit length (MSB first) and
// that many payload bytes pulled from the payload FIFO onto a valid/ready byte link.
module fe_tx_framer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [15:0] tx_cnt,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_CMD,
        HDR_HI,
        HDR_LO,
        FETCH,
        LOAD,
        DATA,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cmd_r;
    logic [7:0]  byte_r;
    logic [15:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        fifo_rd   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = HDR_CMD;
            end
            HDR_CMD: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nxt = HDR_HI;
            end
            HDR_HI: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nxt = HDR_LO;
            end
            HDR_LO: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nxt = (rem == 16'd0) ? DONE : FETCH;
            end
            FETCH: begin
                // A read is only issued once the FIFO reports data; the wait is unbounded.
                fifo_rd = !fifo_empty;
                if (!fifo_empty) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = DATA;
            end
            DATA: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nxt = (rem == 16'd1) ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r  <= 8'h00;
            rem    <= 16'h0000;
            byte_r <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_r <= cmd;
                        rem   <= tx_cnt;
                    end
                end
                HDR_CMD: begin
                    if (tx_ready) byte_r <= rem[15:8];
                end
                HDR_HI: begin
                    if (tx_ready) byte_r <= rem[7:0];
                end
                LOAD: begin
                    byte_r <= fifo_rdata;
                end
                DATA: begin
                    if (tx_ready && rem != 16'd0) rem <= rem - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // The command byte is presented straight from its latch so it stays put through stalls.
    assign tx_data = (state == HDR_CMD) ? cmd_r : byte_r;

endmodule

// File: tb/tb_fe_tx_framer.sv
// Scoreboard bench for fe_tx_framer with a behavioural FIFO (read data one cycle after fifo_rd).
module tb_fe_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cmd;
    logic [15:0] tx_cnt;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    fe_tx_framer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd        (cmd),
        .tx_cnt     (tx_cnt),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_rdata (fifo_rdata),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: stimulus writes mem/wr_cnt, the clocked block advances rd_cnt.
    logic [7:0] mem [0:1023];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign fifo_empty = (wr_cnt <= rd_cnt);

    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_rdata <= mem[rd_cnt % 1024];
            rd_cnt     <= rd_cnt + 1;
        end
    end

    int         exp_q[$];   // header bytes, or -1 meaning "next payload byte"
    logic [7:0] pay_q[$];

    task automatic push_fifo(input logic [7:0] b);
        mem[wr_cnt % 1024] = b;
        wr_cnt++;
        pay_q.push_back(b);
    endtask

    int         xfer_cnt  = 0;
    int         done_cnt  = 0;
    int         rd_seen   = 0;
    int         sp_cnt    = 0;
    int         stab_bad  = 0;
    bit         stalled   = 1'b0;
    logic [7:0] held      = 8'h00;
    int         mon_e;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && (!tx_valid || tx_data !== held)) stab_bad++;
            if (fifo_rd && fifo_empty) sp_cnt++;
            if (fifo_rd) rd_seen++;
            if (done) done_cnt++;
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    mon_e = 'h1FF;
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e < 0) mon_e = (pay_q.size() != 0) ? int'(pay_q.pop_front()) : 'h1FF;
                end
                chk("tx_byte", {24'h0, tx_data}, mon_e);
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
        end
    end

    bit rnd = 1'b0;

    task automatic launch(input logic [7:0] c, input logic [15:0] n);
        exp_q.push_back(int'(c));
        exp_q.push_back(int'(n[15:8]));
        exp_q.push_back(int'(n[7:0]));
        for (int i = 0; i < int'(n); i++) exp_q.push_back(-1);
        cmd    = c;
        tx_cnt = n;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cmd    = 8'h00;
        tx_cnt = 16'h0000;
    endtask

    // Called in cycle 1 of a frame; returns at the falling edge of the cycle after done.
    task automatic wait_done(input int exp_cyc, input int p1, input int p2, input int budget);
        int got;
        int nb;
        got = -1;
        nb  = 0;
        for (int c = 1; c <= budget; c++) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == p1 || c == p2) begin
                start  = 1'b1;
                cmd    = 8'hEE;
                tx_cnt = 16'd7;
            end
            @(negedge clk);
            if (!busy) nb++;
            if (done) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (got < 0) chk("done_timeout", got, budget);
        else if (exp_cyc > 0) chk("done_cycle", got, exp_cyc);
        chk("busy_low_cycles", nb, 0);
        chk("sb_left", exp_q.size(), 0);
        @(posedge clk); #1;
        start    = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_done", {30'h0, busy, done}, 0);
    endtask

    int d0, r0, x0, s0;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        cmd      = 8'h00;
        tx_cnt   = 16'h0000;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {19'h0, tx_valid, tx_data, fifo_rd, busy, done}, 0);
        @(posedge clk); #1;

        // Basic 3-byte frame
        push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33);
        d0 = done_cnt;
        launch(8'h5A, 16'h0003);
        wait_done(13, 0, 0, 100);
        chk("t1_fifo_empty", fifo_empty, 1);
        chk("t1_done_count", done_cnt - d0, 1);

        // Zero-length frame: header only
        r0 = rd_seen; x0 = xfer_cnt;
        launch(8'hC3, 16'h0000);
        wait_done(4, 0, 0, 100);
        chk("t2_fifo_rd", rd_seen - r0, 0);
        chk("t2_xfers", xfer_cnt - x0, 3);

        // 256-byte frame with random back-pressure
        for (int i = 0; i < 256; i++) push_fifo(8'(i));
        d0 = done_cnt; x0 = xfer_cnt; s0 = stab_bad;
        rnd = 1'b1;
        launch(8'hC3, 16'h0100);
        wait_done(-1, 0, 0, 5000);
        rnd = 1'b0;
        chk("t3_xfers", xfer_cnt - x0, 259);
        chk("t3_stable", stab_bad - s0, 0);
        chk("t3_done_count", done_cnt - d0, 1);

        // FIFO starts empty; data trickles in late
        r0 = rd_seen; s0 = sp_cnt;
        launch(8'h42, 16'h0002);
        fork
            wait_done(-1, 0, 0, 300);
            begin
                repeat (20) @(posedge clk);
                #1 push_fifo(8'hAA);
                repeat (10) @(posedge clk);
                #1 push_fifo(8'hBB);
            end
        join
        chk("t4_spurious_rd", sp_cnt - s0, 0);
        chk("t4_reads", rd_seen - r0, 2);

        // Ignored starts mid-payload and in DONE, then back-to-back frame
        push_fifo(8'h01); push_fifo(8'h02);
        d0 = done_cnt;
        launch(8'h21, 16'h0002);
        wait_done(10, 6, 10, 100);
        push_fifo(8'h99);
        launch(8'h34, 16'h0001);
        wait_done(7, 0, 0, 100);
        chk("t5_done_count", done_cnt - d0, 2);

        // Reset after HDR_HI transfer aborts the frame; unread bytes stay queued
        for (int i = 0; i < 5; i++) push_fifo(8'(8'h50 + i));
        d0 = done_cnt; r0 = rd_seen;
        launch(8'h77, 16'h0005);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_outputs", {19'h0, tx_valid, tx_data, fifo_rd, busy, done}, 0);
        repeat (20) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_no_read", rd_seen - r0, 0);
        chk("t6_fifo_level", wr_cnt - rd_cnt, 5);
        launch(8'h78, 16'h0005);
        wait_done(19, 0, 0, 100);
        chk("t6_fifo_empty", fifo_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
